// File: rtl/mpmc11_strm_rdbuf.sv
// Show-ahead stream read buffer for the mpmc11 controller: tags DRAM read beats and presents them over valid/ready.
// Optional MPMC11_STRM_SEQ_TID_EN adds a per-strip sequence number as the beat tranid.
module mpmc11_strm_rdbuf #(
   parameter int         DATA_WIDTH   = 256,
   parameter int         DEPTH        = 16,
   parameter int         AFULL_THRESH = DEPTH - 4,
   parameter logic [5:0] TID_CORE     = 6'h3f
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr,
   input  logic [31:0]                wadr,
   input  logic [DATA_WIDTH-1:0]      wdat,
   input  logic                       last_strip,
   input  logic                       resp_rdy,
   input  logic                       clr_ovf,
   output logic                       resp_ack,
   output logic [31:0]                resp_adr,
   output logic [DATA_WIDTH-1:0]      resp_dat,
   output logic [12:0]                resp_tid,
   output logic                       resp_last,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       almost_full,
   output logic                       ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]           mem_adr  [DEPTH];
   logic [DATA_WIDTH-1:0] mem_dat  [DEPTH];
   logic [3:0]            mem_tid  [DEPTH];
   logic                  mem_last [DEPTH];

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] count_n;
   logic          push;
   logic          pop;
   logic [3:0]    push_tid;

   assign pop  = resp_ack & resp_rdy;
   assign push = wr & (~full | pop);

   always_comb begin
      count_n = count;
      case ({push, pop})
         2'b10:   count_n = count + CW'(1);
         2'b01:   count_n = count - CW'(1);
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         count       <= count_n;
         full        <= (count_n == CW'(DEPTH));
         almost_full <= (count_n >= CW'(AFULL_THRESH));
         // A dropped beat sets the flag even if software clears it in the same cycle
         if (wr & full & ~pop)
            ovf <= 1'b1;
         else if (clr_ovf)
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_adr[wptr]  <= wadr;
         mem_dat[wptr]  <= wdat;
         mem_tid[wptr]  <= push_tid;
         mem_last[wptr] <= last_strip;
      end
   end

`ifdef MPMC11_STRM_SEQ_TID_EN
   // Reset value 0 stands for "next tranid is 1", so the sequence never emits 0
   logic [3:0] seq_cnt;

   assign push_tid = (seq_cnt == 4'd0) ? 4'd1 : seq_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         seq_cnt <= 4'd0;
      else if (push)
         seq_cnt <= (last_strip || push_tid == 4'd15) ? 4'd1 : push_tid + 4'd1;
   end
`else
   assign push_tid = 4'd0;
`endif

   assign resp_ack  = (count != '0);
   assign resp_adr  = resp_ack ? mem_adr[rptr] : '0;
   assign resp_dat  = resp_ack ? mem_dat[rptr] : '0;
   assign resp_tid  = resp_ack ? {TID_CORE, 3'd0, mem_tid[rptr]} : '0;
   assign resp_last = resp_ack ? mem_last[rptr] : 1'b0;

endmodule

// File: tb/tb_mpmc11_strm_rdbuf.sv
// Self-checking bench for mpmc11_strm_rdbuf: vector table, directed corner sequences and random traffic
// against a queue-based reference model. Honours MPMC11_STRM_SEQ_TID_EN.
module tb_mpmc11_strm_rdbuf;

   localparam int DW    = 256;
   localparam int DEPTH = 16;
`ifdef MPMC11_STRM_SEQ_TID_EN
   localparam bit SEQ = 1'b1;
`else
   localparam bit SEQ = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          wr;
   logic [31:0]   wadr;
   logic [DW-1:0] wdat;
   logic          last_strip;
   logic          resp_rdy;
   logic          clr_ovf;
   logic          resp_ack;
   logic [31:0]   resp_adr;
   logic [DW-1:0] resp_dat;
   logic [12:0]   resp_tid;
   logic          resp_last;
   logic [4:0]    count;
   logic          full;
   logic          almost_full;
   logic          ovf;

   int n_checks = 0;
   int n_fail   = 0;

   mpmc11_strm_rdbuf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr(wr), .wadr(wadr), .wdat(wdat),
      .last_strip(last_strip), .resp_rdy(resp_rdy), .clr_ovf(clr_ovf),
      .resp_ack(resp_ack), .resp_adr(resp_adr), .resp_dat(resp_dat),
      .resp_tid(resp_tid), .resp_last(resp_last), .count(count),
      .full(full), .almost_full(almost_full), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference model: the buffer is just a FIFO queue of beats plus a sticky flag and a tid sequence
   typedef struct {
      logic [31:0]   adr;
      logic [DW-1:0] dat;
      int            tid;
      logic          last;
   } beat_t;

   beat_t m_q[$];
   bit    m_ovf     = 1'b0;
   int    m_seq_nxt = 1;

   function automatic logic [12:0] exp_tid(int n);
      return 13'h1f80 | (SEQ ? 13'(n) : 13'd0);
   endfunction

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      beat_t h;
      bit    ne;
      ne = (m_q.size() != 0);
      if (ne) h = m_q[0];
      chk("resp_ack", DW'(resp_ack), DW'(ne));
      chk("resp_adr", DW'(resp_adr), ne ? DW'(h.adr) : '0);
      chk("resp_dat", resp_dat, ne ? h.dat : '0);
      chk("resp_tid", DW'(resp_tid), ne ? DW'(exp_tid(h.tid)) : '0);
      chk("resp_last", DW'(resp_last), ne ? DW'(h.last) : '0);
      chk("count", DW'(count), DW'(m_q.size()));
      chk("full", DW'(full), DW'(m_q.size() == DEPTH));
      chk("almost_full", DW'(almost_full), DW'(m_q.size() >= DEPTH - 4));
      chk("ovf", DW'(ovf), DW'(m_ovf));
   endtask

   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [DW-1:0] d,
                                input logic l, input logic r, input logic c);
      bit    do_pop, do_push, is_full;
      beat_t b;
      wr = w; wadr = a; wdat = d; last_strip = l; resp_rdy = r; clr_ovf = c;
      is_full = (m_q.size() == DEPTH);
      do_pop  = (m_q.size() != 0) && r;
      do_push = w && (!is_full || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
         b.adr = a; b.dat = d; b.last = l;
         b.tid = SEQ ? m_seq_nxt : 0;
         m_q.push_back(b);
         if (l) m_seq_nxt = 1;
         else   m_seq_nxt = (m_seq_nxt == 15) ? 1 : m_seq_nxt + 1;
      end
      if (w && is_full && !do_pop) m_ovf = 1'b1;
      else if (c)                  m_ovf = 1'b0;
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   function automatic logic [DW-1:0] rnd_dat();
      logic [DW-1:0] d;
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   typedef struct {
      logic        wr;
      logic [31:0] adr;
      logic        rdy;
      logic        exp_ack;
      logic [31:0] exp_adr;
      int          exp_tidn;
      logic [4:0]  exp_count;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [DW-1:0] a5;
      int            exp_seq[18];
      a5 = {(DW / 8){8'hA5}};
      exp_seq = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};

      vecs[0] = '{1'b1, 32'h1000, 1'b1, 1'b1, 32'h1000, 1, 5'd1};
      vecs[1] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    0, 5'd0};
      vecs[2] = '{1'b1, 32'h2000, 1'b0, 1'b1, 32'h2000, 2, 5'd1};
      vecs[3] = '{1'b1, 32'h3000, 1'b0, 1'b1, 32'h2000, 2, 5'd2};
      vecs[4] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h3000, 3, 5'd1};
      vecs[5] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    0, 5'd0};

      rst = 1'b1; wr = 1'b0; wadr = '0; wdat = '0; last_strip = 1'b0; resp_rdy = 1'b0; clr_ovf = 1'b0;
      #12;
      checkOutput();
      rst = 1'b0;

      // Directed vector table, starting from a freshly reset buffer
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].wr, vecs[i].adr, a5, 1'b0, vecs[i].rdy, 1'b0);
         chk("vec_ack", DW'(resp_ack), DW'(vecs[i].exp_ack));
         chk("vec_adr", DW'(resp_adr), DW'(vecs[i].exp_adr));
         chk("vec_dat", resp_dat, vecs[i].exp_ack ? a5 : '0);
         chk("vec_tid", DW'(resp_tid), vecs[i].exp_ack ? DW'(exp_tid(vecs[i].exp_tidn)) : '0);
         chk("vec_count", DW'(count), DW'(vecs[i].exp_count));
      end

      // Fill past capacity with the master stalled
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 32'(i), rnd_dat(), 1'b0, 1'b0, 1'b0);
         if (i == 10) chk("afull_at_11", DW'(almost_full), '0);
         if (i == 11) chk("afull_at_12", DW'(almost_full), DW'(1));
         if (i == 14) chk("full_at_15", DW'(full), '0);
         if (i == 15) chk("full_at_16", DW'(full), DW'(1));
      end
      chk("ovf_after_drop", DW'(ovf), DW'(1));
      chk("count_after_drop", DW'(count), DW'(16));
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      chk("ovf_cleared", DW'(ovf), '0);
      for (int i = 0; i < 16; i++) begin
         chk("drain_adr", DW'(resp_adr), DW'(i));
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      end
      chk("drained_empty", DW'(resp_ack), '0);

      // Push and pop together while full
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h100 + 32'(i), rnd_dat(), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h200, rnd_dat(), 1'b0, 1'b1, 1'b0);
      chk("full_pushpop_count", DW'(count), DW'(16));
      chk("full_pushpop_ovf", DW'(ovf), '0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

      // Pointer wrap with alternating backpressure, then drain
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 32'h400 + 32'(i), rnd_dat(), 1'b0, i[0], 1'b0);
      for (int i = 0; i < 17; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++)
         applyStimulus(($urandom_range(0, 9) < 7), $urandom, rnd_dat(), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 9) < 5), ($urandom_range(0, 15) == 0));

      // Overflow, then drain to 7 beats and reset between edges
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h800 + 32'(i), rnd_dat(), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      wr = 1'b0; resp_rdy = 1'b0;
      chk("pre_reset_count", DW'(count), DW'(7));
      chk("pre_reset_ovf", DW'(ovf), DW'(1));
      #1 rst = 1'b1;
      #1;
      chk("rst_ack", DW'(resp_ack), '0);
      chk("rst_count", DW'(count), '0);
      chk("rst_ovf", DW'(ovf), '0);
      chk("rst_adr", DW'(resp_adr), '0);
      m_q.delete();
      m_ovf = 1'b0;
      m_seq_nxt = 1;
      #4 rst = 1'b0;

      // Strip sequencing: last_strip on beat 5 restarts the tranid sequence
      for (int i = 0; i < 18; i++) begin
         applyStimulus(1'b1, 32'hA00 + 32'(i), rnd_dat(), (i == 4), 1'b1, 1'b0);
         chk("seq_tid", DW'(resp_tid), DW'(exp_tid(exp_seq[i])));
         chk("seq_last", DW'(resp_last), DW'(i == 4));
      end
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
